// File: rtl/usb_fs_in_pe_pingpong.sv
// USB full-speed IN protocol engine with ping-pong endpoint buffers.
// Two banks per endpoint let the host drain one while the app fills the other.
module usb_fs_in_pe_pingpong #(
  parameter int NUM_IN_EPS = 4,
  parameter int MAX_IN_PACKET_SIZE = 64,
  parameter logic [NUM_IN_EPS-1:0] ISO_EP_MASK = '0,
  parameter int ACK_TIMEOUT = 96
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IN_EPS-1:0] reset_ep,
  input  logic [6:0]            dev_addr,
  output logic [NUM_IN_EPS-1:0] in_ep_data_free,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
  input  logic [7:0]            in_ep_data,
  input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
  input  logic [NUM_IN_EPS-1:0] in_ep_stall,
  output logic [NUM_IN_EPS-1:0] in_ep_acked,
  input  logic                  rx_pkt_end,
  input  logic                  rx_pkt_valid,
  input  logic [3:0]            rx_pid,
  input  logic [6:0]            rx_addr,
  input  logic [3:0]            rx_endp,
  output logic                  tx_pkt_start,
  output logic [3:0]            tx_pid,
  input  logic                  tx_pkt_end,
  output logic                  tx_data_avail,
  input  logic                  tx_data_get,
  output logic [7:0]            tx_data
);

  localparam int AW = $clog2(MAX_IN_PACKET_SIZE);
  localparam int EW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;

  typedef logic [AW:0] ptr_t;
  localparam ptr_t MAXP = ptr_t'(MAX_IN_PACKET_SIZE);
  localparam ptr_t LAST = ptr_t'(MAX_IN_PACKET_SIZE - 1);
  localparam logic [4:0] NEP = 5'(NUM_IN_EPS);
  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, RCVD_IN, SEND_DATA, WAIT_ACK
  } state_t;

  state_t          state;
  logic [EW-1:0]   cur_ep;
  ptr_t            get_ptr;
  logic [7:0]      timer;
  logic            rst_n;

  logic [7:0] mem [NUM_IN_EPS][2][MAX_IN_PACKET_SIZE];
  ptr_t       fill_ptr [NUM_IN_EPS];
  ptr_t       len [NUM_IN_EPS][2];
  logic [1:0] cnt [NUM_IN_EPS];
  logic [NUM_IN_EPS-1:0] fill_bank;
  logic [NUM_IN_EPS-1:0] send_bank;
  logic [NUM_IN_EPS-1:0] stall;
  logic [NUM_IN_EPS-1:0] toggle;

  logic [NUM_IN_EPS-1:0] put_ok;
  logic [NUM_IN_EPS-1:0] commit;
  logic [NUM_IN_EPS-1:0] rel_ep;
  logic [NUM_IN_EPS-1:0] flush;
  logic                  wr_en;
  logic [EW-1:0]         wr_ep;
  logic                  wr_bank;
  logic [AW-1:0]         wr_ptr;

  logic          tok;
  logic          in_tok;
  logic          setup_tok;
  logic          ack_rx;
  logic [EW-1:0] tok_ep;
  logic          cur_rst;
  logic          iso_cur;
  logic          avail;
  logic          rel_go;
  logic          flip;

  assign tok = rx_pkt_end && rx_pkt_valid &&
               rx_pid[1:0] == 2'b01 &&
               rx_addr == dev_addr &&
               {1'b0, rx_endp} < NEP;
  assign in_tok    = tok && rx_pid == 4'b1001;
  assign setup_tok = tok && rx_pid == 4'b1101;
  assign ack_rx    = rx_pkt_end && rx_pkt_valid &&
                     rx_pid == 4'b0010;
  assign tok_ep    = rx_endp[EW-1:0];
  assign cur_rst   = reset_ep[cur_ep];
  assign iso_cur   = ISO_EP_MASK[cur_ep];
  assign avail     = state == SEND_DATA &&
                     get_ptr < len[cur_ep][send_bank[cur_ep]];
  assign tx_data_avail = avail;
  assign flip   = state == WAIT_ACK && ack_rx && !cur_rst;
  assign rel_go = flip ||
                  (state == SEND_DATA && iso_cur && !avail &&
                   tx_pkt_end && !cur_rst);

  // Per-endpoint fill/commit/release decode and the single write port.
  always_comb begin
    in_ep_data_free = '0;
    put_ok  = '0;
    commit  = '0;
    rel_ep  = '0;
    flush   = '0;
    wr_en   = 1'b0;
    wr_ep   = '0;
    wr_bank = 1'b0;
    wr_ptr  = '0;
    for (int e = 0; e < NUM_IN_EPS; e++) begin
      in_ep_data_free[e] = rst_n && cnt[e] < 2'd2 &&
                           fill_ptr[e] < MAXP && !stall[e];
      put_ok[e] = in_ep_data_put[e] && in_ep_data_free[e];
      commit[e] = cnt[e] < 2'd2 &&
                  ((put_ok[e] && fill_ptr[e] == LAST) ||
                   in_ep_data_done[e]);
      rel_ep[e] = rel_go && cur_ep == EW'(e);
      flush[e]  = reset_ep[e] ||
                  (setup_tok && tok_ep == EW'(e));
      if (put_ok[e]) begin
        wr_en   = 1'b1;
        wr_ep   = EW'(e);
        wr_bank = fill_bank[e];
        wr_ptr  = fill_ptr[e][AW-1:0];
      end
    end
  end

  // Reset release is re-timed to clk; assertion stays asynchronous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_n <= 1'b0;
    else        rst_n <= 1'b1;
  end

  // Packet byte storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ep][wr_bank][wr_ptr] <= in_ep_data;
  end

  // Endpoint bookkeeping: fill pointer, bank counts, stall and toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_bank   <= '0;
      send_bank   <= '0;
      stall       <= '0;
      toggle      <= '0;
      in_ep_acked <= '0;
      for (int e = 0; e < NUM_IN_EPS; e++) begin
        fill_ptr[e] <= '0;
        cnt[e]      <= '0;
        len[e][0]   <= '0;
        len[e][1]   <= '0;
      end
    end else begin
      in_ep_acked <= rel_ep;
      for (int e = 0; e < NUM_IN_EPS; e++) begin
        if (flush[e]) begin
          fill_ptr[e]  <= '0;
          cnt[e]       <= '0;
          fill_bank[e] <= 1'b0;
          send_bank[e] <= 1'b0;
          stall[e]     <= 1'b0;
          toggle[e]    <= !reset_ep[e];
        end else begin
          stall[e] <= stall[e] | in_ep_stall[e];
          if (commit[e]) begin
            len[e][fill_bank[e]] <= fill_ptr[e] + ptr_t'(put_ok[e]);
            fill_ptr[e]  <= '0;
            fill_bank[e] <= ~fill_bank[e];
          end else if (put_ok[e]) begin
            fill_ptr[e] <= fill_ptr[e] + ptr_t'(1);
          end
          if (commit[e] && !rel_ep[e]) cnt[e] <= cnt[e] + 2'd1;
          if (!commit[e] && rel_ep[e]) cnt[e] <= cnt[e] - 2'd1;
          if (rel_ep[e]) send_bank[e] <= ~send_bank[e];
          if (rel_ep[e] && flip) toggle[e] <= ~toggle[e];
        end
      end
    end
  end

  // Transfer FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_ep       <= '0;
      get_ptr      <= '0;
      timer        <= '0;
      tx_pkt_start <= 1'b0;
      tx_pid       <= '0;
      tx_data      <= '0;
    end else begin
      tx_pkt_start <= 1'b0;
      tx_data <= mem[cur_ep][send_bank[cur_ep]][get_ptr[AW-1:0]];
      if (state != IDLE && cur_rst) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_tok) begin
              cur_ep <= tok_ep;
              state  <= RCVD_IN;
            end
          end
          RCVD_IN: begin
            tx_pkt_start <= 1'b1;
            get_ptr      <= '0;
            unique case (1'b1)
              stall[cur_ep]: begin
                tx_pid <= 4'b1110;
                state  <= IDLE;
              end
              (!stall[cur_ep] && cnt[cur_ep] != 2'd0): begin
                tx_pid <= iso_cur ? 4'b0011
                                  : {toggle[cur_ep], 3'b011};
                state  <= SEND_DATA;
              end
              default: begin
                tx_pid <= 4'b1010;
                state  <= IDLE;
              end
            endcase
          end
          SEND_DATA: begin
            timer <= '0;
            if (avail && tx_data_get) begin
              get_ptr <= get_ptr + ptr_t'(1);
            end else if (!avail) begin
              if (!iso_cur)        state <= WAIT_ACK;
              else if (tx_pkt_end) state <= IDLE;
            end
          end
          WAIT_ACK: begin
            timer <= timer + 8'd1;
            if (ack_rx) begin
              state <= IDLE;
            end else if (in_tok) begin
              cur_ep  <= tok_ep;
              get_ptr <= '0;
              state   <= RCVD_IN;
            end else if (rx_pkt_end || timer == TMO) begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_fs_in_pe_pingpong.sv
// Randomised bench for usb_fs_in_pe_pingpong.
// Reference model keeps committed packets as byte/length queues.
module tb_usb_fs_in_pe_pingpong;

  localparam int NEP = 4;
  localparam int MAXB = 64;
  localparam int TMO = 96;
  localparam logic [3:0] ISO = 4'b1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] reset_ep = '0;
  logic [6:0] dev_addr = '0;
  logic [3:0] in_ep_data_free;
  logic [3:0] in_ep_data_put = '0;
  logic [7:0] in_ep_data = '0;
  logic [3:0] in_ep_data_done = '0;
  logic [3:0] in_ep_stall = '0;
  logic [3:0] in_ep_acked;
  logic       rx_pkt_end = 1'b0;
  logic       rx_pkt_valid = 1'b0;
  logic [3:0] rx_pid = '0;
  logic [6:0] rx_addr = '0;
  logic [3:0] rx_endp = '0;
  logic       tx_pkt_start;
  logic [3:0] tx_pid;
  logic       tx_pkt_end = 1'b0;
  logic       tx_data_avail;
  logic       tx_data_get = 1'b0;
  logic [7:0] tx_data;

  int total = 0;
  int bad = 0;

  logic [7:0] sq [NEP][$];
  logic [7:0] bq [NEP][$];
  int         lq [NEP][$];
  bit         stl [NEP];
  bit         tog [NEP];

  usb_fs_in_pe_pingpong #(
    .NUM_IN_EPS(NEP),
    .MAX_IN_PACKET_SIZE(MAXB),
    .ISO_EP_MASK(ISO),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reset_ep(reset_ep),
    .dev_addr(dev_addr),
    .in_ep_data_free(in_ep_data_free),
    .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data),
    .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall),
    .in_ep_acked(in_ep_acked),
    .rx_pkt_end(rx_pkt_end),
    .rx_pkt_valid(rx_pkt_valid),
    .rx_pid(rx_pid),
    .rx_addr(rx_addr),
    .rx_endp(rx_endp),
    .tx_pkt_start(tx_pkt_start),
    .tx_pid(tx_pid),
    .tx_pkt_end(tx_pkt_end),
    .tx_data_avail(tx_data_avail),
    .tx_data_get(tx_data_get),
    .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  function automatic bit m_free(int e);
    return lq[e].size() < 2 && !stl[e];
  endfunction

  function automatic void m_commit(int e);
    lq[e].push_back(sq[e].size());
    for (int i = 0; i < sq[e].size(); i++)
      bq[e].push_back(sq[e][i]);
    sq[e].delete();
  endfunction

  function automatic void m_release(int e);
    int n;
    n = lq[e].pop_front();
    for (int i = 0; i < n; i++) void'(bq[e].pop_front());
  endfunction

  function automatic void m_flush(int e, bit t);
    sq[e].delete();
    bq[e].delete();
    lq[e].delete();
    stl[e] = 1'b0;
    tog[e] = t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_free(input string tag);
    logic [3:0] exp;
    for (int e = 0; e < NEP; e++) exp[e] = m_free(e);
    total++;
    if (in_ep_data_free !== exp) begin
      bad++;
      $display("FAIL free_%s got=%b exp=%b", tag,
               in_ep_data_free, exp);
    end
  endtask

  task automatic put_byte(input int e, input logic [7:0] b);
    bit ef;
    ef = m_free(e);
    total++;
    if (in_ep_data_free[e] !== ef) begin
      bad++;
      $display("FAIL put_free ep%0d got=%b exp=%b", e,
               in_ep_data_free[e], ef);
    end
    in_ep_data_put = '0;
    in_ep_data_put[e] = 1'b1;
    in_ep_data = b;
    tick();
    in_ep_data_put = '0;
    if (ef) begin
      sq[e].push_back(b);
      if (sq[e].size() == MAXB) m_commit(e);
    end
  endtask

  task automatic put_n(input int e, input int n);
    for (int i = 0; i < n; i++) put_byte(e, 8'($urandom));
  endtask

  task automatic send_done(input int e);
    in_ep_data_done = '0;
    in_ep_data_done[e] = 1'b1;
    tick();
    in_ep_data_done = '0;
    if (lq[e].size() < 2) m_commit(e);
  endtask

  task automatic send_rx(input logic [3:0] pid,
                         input logic [6:0] addr,
                         input int ep);
    rx_pid = pid;
    rx_addr = addr;
    rx_endp = 4'(ep);
    rx_pkt_end = 1'b1;
    rx_pkt_valid = 1'b1;
    tick();
    rx_pkt_end = 1'b0;
    rx_pkt_valid = 1'b0;
  endtask

  task automatic pulse_reset_ep(input int e);
    reset_ep[e] = 1'b1;
    tick();
    reset_ep = '0;
    m_flush(e, 1'b0);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tx_pkt_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL start_timeout got=0 exp=1");
    end
  endtask

  // mode: 0 ACK, 1 let it time out, 2 leave waiting, 3 foreign packet
  task automatic do_in(input int e, input int mode);
    logic [3:0] exp;
    logic [3:0] av;
    bit ok;
    int n;
    bit hold;
    if (stl[e]) exp = 4'b1110;
    else if (lq[e].size() > 0)
      exp = ISO[e] ? 4'b0011 : {tog[e], 3'b011};
    else exp = 4'b1010;
    send_rx(4'b1001, dev_addr, e);
    wait_start(ok);
    if (!ok) return;
    total++;
    if (tx_pid !== exp) begin
      bad++;
      $display("FAIL pid ep%0d got=%b exp=%b", e, tx_pid, exp);
    end
    if (exp == 4'b1110 || exp == 4'b1010) return;
    n = lq[e][0];
    for (int i = 0; i < n; i++) begin
      total++;
      if (tx_data_avail !== 1'b1) begin
        bad++;
        $display("FAIL avail_hi ep%0d i=%0d got=0 exp=1", e, i);
      end
      repeat ($urandom_range(0, 2)) tick();
      tx_data_get = 1'b1;
      tick();
      tx_data_get = 1'b0;
      total++;
      if (tx_data !== bq[e][i]) begin
        bad++;
        $display("FAIL data ep%0d i=%0d got=%h exp=%h", e, i,
                 tx_data, bq[e][i]);
      end
    end
    total++;
    if (tx_data_avail !== 1'b0) begin
      bad++;
      $display("FAIL avail_lo ep%0d got=1 exp=0", e);
    end
    av = 4'(1) << e;
    if (ISO[e]) begin
      tx_pkt_end = 1'b1;
      tick();
      tx_pkt_end = 1'b0;
      total++;
      if (in_ep_acked !== av) begin
        bad++;
        $display("FAIL iso_acked got=%b exp=%b", in_ep_acked, av);
      end
      m_release(e);
      return;
    end
    tick();
    case (mode)
      0: begin
        send_rx(4'b0010, 7'd0, 0);
        total++;
        if (in_ep_acked !== av) begin
          bad++;
          $display("FAIL acked got=%b exp=%b", in_ep_acked, av);
        end
        m_release(e);
        tog[e] = !tog[e];
      end
      1: begin
        hold = 1'b1;
        repeat (TMO + 4) begin
          tick();
          if (in_ep_acked !== 4'b0000) hold = 1'b0;
        end
        total++;
        if (!hold) begin
          bad++;
          $display("FAIL tmo_acked got=pulse exp=none");
        end
      end
      3: begin
        send_rx(4'b0011, dev_addr, 0);
        total++;
        if (in_ep_acked !== 4'b0000) begin
          bad++;
          $display("FAIL rb_acked got=%b exp=0000", in_ep_acked);
        end
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({in_ep_data_free, in_ep_acked, tx_pkt_start, tx_pid,
         tx_data_avail, tx_data} !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%b/%b/%b/%h/%b/%h exp=0",
               in_ep_data_free, in_ep_acked, tx_pkt_start, tx_pid,
               tx_data_avail, tx_data);
    end
    reset = 1'b1;
    repeat (3) tick();
    check_free("after_reset");
  endtask

  task automatic test_full_packet();
    put_n(1, 64);
    check_free("full64");
    do_in(1, 0);
    check_free("full64_acked");
  endtask

  task automatic test_reset_ep();
    put_n(1, 3);
    send_done(1);
    pulse_reset_ep(1);
    check_free("reset_ep");
    do_in(1, 0);
  endtask

  task automatic test_two_packets();
    put_n(1, 74);
    send_done(1);
    check_free("two_full");
    do_in(1, 0);
    check_free("two_first_acked");
    do_in(1, 0);
  endtask

  task automatic test_nak_zero();
    do_in(2, 0);
    send_done(2);
    do_in(2, 0);
  endtask

  task automatic test_timeout();
    put_n(1, 5);
    send_done(1);
    do_in(1, 1);
    do_in(1, 0);
  endtask

  task automatic test_stall_setup();
    in_ep_stall[0] = 1'b1;
    tick();
    in_ep_stall = '0;
    stl[0] = 1'b1;
    check_free("stalled");
    do_in(0, 0);
    send_rx(4'b1101, dev_addr, 0);
    m_flush(0, 1'b1);
    put_n(0, 8);
    send_done(0);
    do_in(0, 0);
  endtask

  task automatic test_iso();
    put_n(3, 20);
    send_done(3);
    put_n(3, 5);
    send_done(3);
    do_in(3, 0);
    do_in(3, 0);
    check_free("iso_done");
  endtask

  task automatic test_bad_token();
    bit seen;
    seen = 1'b0;
    send_rx(4'b1001, dev_addr ^ 7'd1, 1);
    repeat (6) begin
      if (tx_pkt_start === 1'b1) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL wrong_addr got=start exp=none");
    end
    seen = 1'b0;
    send_rx(4'b1001, dev_addr, 5);
    repeat (6) begin
      if (tx_pkt_start === 1'b1) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL bad_endp got=start exp=none");
    end
  endtask

  task automatic test_random();
    int op;
    int e;
    int m;
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 9);
      e = $urandom_range(0, 3);
      if (op < 4) begin
        put_n(e, $urandom_range(1, 70));
      end else if (op < 5) begin
        send_done(e);
      end else if (op < 9) begin
        case ($urandom_range(0, 3))
          2: m = 2;
          3: m = 3;
          default: m = 0;
        endcase
        do_in(e, m);
      end else begin
        pulse_reset_ep(e);
      end
    end
    check_free("random_end");
  endtask

  initial begin
    for (int e = 0; e < NEP; e++) m_flush(e, 1'b0);
    dev_addr = 7'($urandom_range(1, 126));
    test_reset();
    test_full_packet();
    test_reset_ep();
    test_two_packets();
    test_nak_zero();
    test_timeout();
    test_stall_setup();
    test_iso();
    test_bad_token();
    test_random();
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
